sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
Parametrised synchronous FIFO. Extends the basic single-clock FIFO with an occupancy count, programmable almost-full and almost-empty thresholds, and one-cycle overflow/underflow error pulses. It also adds a synchronous flush and a compile-time first-word-fall-through (FWFT) mode. It sits between single-clock producer and consumer blocks and is the standard buffer for new datapaths.

Parameters:
DATA_WIDTH, 32, width of each data word.
FIFO_DEPTH, 8, number of entries; must be a power of 2 and at least 2.
AFULL_THRESH, 6, almost_full is asserted when count >= AFULL_THRESH; legal range 1..FIFO_DEPTH.
AEMPTY_THRESH, 2, almost_empty is asserted when count <= AEMPTY_THRESH; legal range 0..FIFO_DEPTH-1.
FWFT, 0, read mode: 0 selects a registered read, 1 selects first-word-fall-through.

Ports:
clk  in  1  single clock; all logic samples on the rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  synchronous clear of all FIFO contents.
wr_en  in  1  write request.
data_in  in  DATA_WIDTH  write data.
rd_en  in  1  read request, or pop in FWFT mode.
data_out  out  DATA_WIDTH  read data.
empty  out  1  count == 0.
full  out  1  count == FIFO_DEPTH.
almost_full  out  1  count >= AFULL_THRESH.
almost_empty  out  1  count <= AEMPTY_THRESH.
count  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
overflow  out  1  one-cycle pulse when a write is rejected.
underflow  out  1  one-cycle pulse when a read is rejected.

Behaviour:
Clock and reset:
- One clock; reset is asynchronous and active-high.
- rst asserted takes effect immediately, regardless of clk:
  - wr_ptr = rd_ptr = 0, count = 0, data_out = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0.
- rst asserted mid-operation discards all stored data. No write or read is accepted in the cycle rst deasserts.

Pointers and count:
- Pointers are $clog2(FIFO_DEPTH)+1 bits wide; the MSB is the wrap bit.
- Storage index is ptr[$clog2(FIFO_DEPTH)-1:0]. Pointers wrap naturally from FIFO_DEPTH-1 back to 0.
- count is a registered counter, not derived from the pointers.
- All flags are combinational from count; they are therefore valid in the same cycle count changes.

Write and read acceptance:
- wr_acc = wr_en & (~full | rd_acc).
- rd_acc = rd_en & ~empty.
- Consequence when full: simultaneous wr_en and rd_en are both accepted and count is unchanged.
- Consequence when empty: simultaneous wr_en and rd_en accept only the write; count goes to 1 and underflow pulses.
- overflow is registered: 1 for exactly the cycle after an edge where wr_en & ~wr_acc.
- underflow is registered: 1 for exactly the cycle after an edge where rd_en & ~rd_acc.
- Rejected requests do not change pointers, count or memory.

Count update:
- +1 on wr_acc & ~rd_acc.
- -1 on rd_acc & ~wr_acc.
- Unchanged otherwise.

Read timing, FWFT = 0:
- On an edge with rd_acc, data_out is loaded with mem[rd_ptr].
- The word is visible after that edge, i.e. one-cycle latency.
- data_out holds its value when there is no accepted read.

Read timing, FWFT = 1:
- data_out = mem[rd_ptr] combinationally whenever empty = 0.
- rd_en pops the head entry. data_out is don't-care while empty = 1.
- A word written into an empty FIFO appears on data_out the cycle after the write edge.

Flush:
- On an edge with flush = 1, pointers, count and data_out clear as for reset.
- flush has priority over wr_en and rd_en in the same cycle; neither overflow nor underflow pulses.

Memory:
- Memory contents are not reset.
- Storage is an inferred register array with a synchronous write.

Decomposition:
- Package sync_fifo_pkg holds:
  - the localparam function for pointer width, i.e. clog2 of depth plus 1;
  - a typedef for the count type;
  - an enum fifo_mode_e with values REG and FWFT, mapped to the FWFT parameter.
- One sub-module, fifo_mem: a parametrised DATA_WIDTH x FIFO_DEPTH dual-port register file with a synchronous write port and an asynchronous read port.
- The top level holds the pointers, count, flags, error pulses and the data_out register.

Test Plan:
1. FWFT = 0. Reset, then write 1, 10, 100, then three reads -> data_out = 1, 10, 100, each one cycle after its rd_en edge. count goes 1, 2, 3, 2, 1, 0. empty = 1 at the end. No error pulses.
2. Write 2**i for i = 0..8 into a depth-8 FIFO -> full = 1 after the 8th write. The 9th write (256) is rejected and overflow pulses for one cycle. Eight reads then return 1..128 in order. Reading once more on empty makes underflow pulse and leaves data_out = 128.
3. Default thresholds (6 and 2). Fill from 0 to 8 -> almost_empty = 1 for count 0..2. almost_full goes to 1 when count reaches 6. Drain reverses both flags at the same counts.
4. Fill to 8 entries, then drive wr_en = 1 and rd_en = 1 together for 4 cycles with data 0xA0..0xA3 -> count stays 8 and no overflow. The next 8 reads return 5..8 (entries previously written as those values) followed by 0xA0..0xA3, exercising pointer wrap.
5. FWFT = 1. Write 0x55 into an empty FIFO -> data_out = 0x55 one cycle later with no rd_en. Pulsing rd_en then sets empty = 1.
6. Reset and flush. Write 3 words, assert rst asynchronously between clock edges -> count = 0 and empty = 1 immediately. Write 3 words again, then assert flush together with wr_en -> count = 0, data_out = 0, no overflow pulse.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the flagged synchronous FIFO.
// Pointer width, count type and read-mode encoding.
package sync_fifo_pkg;

    typedef enum logic {
        REG  = 1'b0,
        FWFT = 1'b1
    } fifo_mode_e;

    typedef int unsigned count_t;

    // Pointers carry one extra wrap bit above the storage index.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic at_least(input count_t value, input count_t thresh);
        return value >= thresh;
    endfunction

    function automatic logic at_most(input count_t value, input count_t thresh);
        return value <= thresh;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DATA_WIDTH x FIFO_DEPTH register file: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module fifo_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          wr_en_i,
    input  logic [$clog2(FIFO_DEPTH)-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0]         wr_data_i,
    input  logic [$clog2(FIFO_DEPTH)-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0]         rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered occupancy count, threshold flags, error pulses,
// synchronous flush and optional first-word-fall-through read.
module sync_fifo_flags #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned AFULL_THRESH  = 6,
    parameter int unsigned AEMPTY_THRESH = 2,
    parameter int unsigned FWFT          = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        rd_en,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        empty,
    output logic                        full,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow,
    output logic                        underflow
);
    import sync_fifo_pkg::*;

    localparam int unsigned PtrW  = ptr_width(FIFO_DEPTH);
    localparam int unsigned AddrW = PtrW - 1;
    localparam fifo_mode_e  Mode  = (FWFT != 0) ? sync_fifo_pkg::FWFT : REG;
    localparam logic [PtrW-1:0] DepthC = PtrW'(FIFO_DEPTH);

    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]       count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_mem (
        .clk      (clk),
        .wr_en_i  (wr_acc & ~flush),
        .wr_addr_i(wr_ptr_q[AddrW-1:0]),
        .wr_data_i(data_in),
        .rd_addr_i(rd_ptr_q[AddrW-1:0]),
        .rd_data_o(mem_rd_data)
    );

    always_comb begin
        // A write into a full FIFO is still taken when a read frees a slot this cycle.
        rd_acc   = rd_en & ~empty;
        wr_acc   = wr_en & (~full | rd_acc);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        ovf_d    = wr_en & ~wr_acc;
        unf_d    = rd_en & ~rd_acc;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            dout_d   = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                dout_d   = mem_rd_data;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == DepthC);
    assign almost_full  = at_least(count_t'(count_q), AFULL_THRESH);
    assign almost_empty = at_most(count_t'(count_q), AEMPTY_THRESH);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign data_out     = (Mode == sync_fifo_pkg::FWFT) ? (empty ? '0 : mem_rd_data) : dout_q;

    // The registered count must always agree with the pointer distance.
    count_matches_ptrs: assert property (@(posedge clk) disable iff (rst)
        count_q == PtrW'(wr_ptr_q - rd_ptr_q));

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench: table-driven vectors against a queue model and a read-data
// scoreboard, plus hand sequences for async reset, flush and FWFT mode.
module tb_sync_fifo_flags;

    localparam int DW = 32;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush, wr_en, rd_en;
    logic [DW-1:0] data_in, data_out;
    logic          empty, full, almost_full, almost_empty, overflow, underflow;
    logic [3:0]    count;

    logic          flush2, wr_en2, rd_en2;
    logic [DW-1:0] data_in2, data_out2;
    logic          empty2, full2, almost_full2, almost_empty2, overflow2, underflow2;
    logic [3:0]    count2;

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(D), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(0)
    ) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(data_out), .empty(empty), .full(full),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_flags #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(D), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(1)
    ) u_dut_fwft (
        .clk(clk), .rst(rst), .flush(flush2), .wr_en(wr_en2), .data_in(data_in2),
        .rd_en(rd_en2), .data_out(data_out2), .empty(empty2), .full(full2),
        .almost_full(almost_full2), .almost_empty(almost_empty2), .count(count2),
        .overflow(overflow2), .underflow(underflow2)
    );

    typedef struct {
        bit            wr;
        bit            rd;
        bit            fl;
        logic [DW-1:0] din;
        int            exp_cnt;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] mq[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] m_dout;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit wr, input bit rd, input bit fl,
                                input logic [DW-1:0] din, input int c);
        vec_t v;
        v.wr = wr; v.rd = rd; v.fl = fl; v.din = din; v.exp_cnt = c;
        return v;
    endfunction

    // Called one time unit after a rising edge; drives one cycle and checks after the edge.
    task automatic apply(input vec_t v);
        bit m_empty, m_full, ra, wa, eo, eu;
        m_empty = (mq.size() == 0);
        m_full  = (mq.size() == D);
        ra = v.rd && !m_empty && !v.fl;
        wa = v.wr && (!m_full || (v.rd && !m_empty)) && !v.fl;
        eo = !v.fl && v.wr && !wa;
        eu = !v.fl && v.rd && m_empty;
        wr_en = v.wr; rd_en = v.rd; flush = v.fl; data_in = v.din;
        if (v.fl) begin
            mq.delete();
            m_dout = '0;
        end else begin
            if (ra) sb.push_back(mq.pop_front());
            if (wa) mq.push_back(v.din);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
        chk("count", DW'(count), v.exp_cnt);
        chk("empty", DW'(empty), DW'(mq.size() == 0));
        chk("full", DW'(full), DW'(mq.size() == D));
        chk("almost_full", DW'(almost_full), DW'(mq.size() >= 6));
        chk("almost_empty", DW'(almost_empty), DW'(mq.size() <= 2));
        chk("overflow", DW'(overflow), DW'(eo));
        chk("underflow", DW'(underflow), DW'(eu));
        if (sb.size() > 0) begin
            m_dout = sb.pop_front();
            chk("rd_data", data_out, m_dout);
        end else begin
            chk("data_hold", data_out, m_dout);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        flush = 0; wr_en = 0; rd_en = 0; data_in = '0;
        flush2 = 0; wr_en2 = 0; rd_en2 = 0; data_in2 = '0;
        m_dout = '0;

        // Basic write/read, then fill past full, then thresholds, then full-throughput wrap.
        vecs.push_back(mk(1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 10, 2));
        vecs.push_back(mk(1, 0, 0, 100, 3));
        vecs.push_back(mk(0, 1, 0, 0, 2));
        vecs.push_back(mk(0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0));
        for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 0, 0, 32'(1) << i, i + 1));
        vecs.push_back(mk(1, 0, 0, 256, 8));
        vecs.push_back(mk(0, 0, 0, 0, 8));
        for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 1, 0, 0, 7 - i));
        vecs.push_back(mk(0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 0, 0, 'h30 + i, i + 1));
        for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 1, 0, 0, 7 - i));
        for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 0, 0, i + 1, i + 1));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 1, 0, 'hA0 + i, 8));
        for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 1, 0, 0, 7 - i));

        #1;
        chk("rst_count", DW'(count), 0);
        chk("rst_empty", DW'(empty), 1);
        chk("rst_almost_empty", DW'(almost_empty), 1);
        chk("rst_full", DW'(full), 0);
        chk("rst_almost_full", DW'(almost_full), 0);
        chk("rst_overflow", DW'(overflow), 0);
        chk("rst_underflow", DW'(underflow), 0);
        chk("rst_data_out", data_out, 0);
        #11;
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) apply(vecs[i]);

        // Asynchronous reset between edges clears state immediately.
        for (int i = 0; i < 3; i++) apply(mk(1, 0, 0, 'hC0 + i, i + 1));
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_count", DW'(count), 0);
        chk("async_rst_empty", DW'(empty), 1);
        chk("async_rst_data_out", data_out, 0);
        mq.delete(); sb.delete(); m_dout = '0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Flush beats a concurrent write, and later a concurrent write+read on a full FIFO.
        for (int i = 0; i < 3; i++) apply(mk(1, 0, 0, 'hD0 + i, i + 1));
        apply(mk(0, 1, 0, 0, 2));
        apply(mk(1, 0, 1, 'hEE, 0));
        for (int i = 0; i < 8; i++) apply(mk(1, 0, 0, 'hE0 + i, i + 1));
        apply(mk(1, 1, 1, 'hFF, 0));
        apply(mk(0, 1, 0, 0, 0));
        apply(mk(1, 0, 0, 'h77, 1));
        apply(mk(0, 1, 0, 0, 0));

        // FWFT: head word visible the cycle after it is written, no read needed.
        wr_en2 = 1'b1; data_in2 = 'h55;
        @(posedge clk); #1;
        wr_en2 = 1'b0;
        chk("fwft_data", data_out2, 'h55);
        chk("fwft_empty", DW'(empty2), 0);
        chk("fwft_count", DW'(count2), 1);
        rd_en2 = 1'b1;
        @(posedge clk); #1;
        rd_en2 = 1'b0;
        chk("fwft_pop_empty", DW'(empty2), 1);
        chk("fwft_pop_count", DW'(count2), 0);
        wr_en2 = 1'b1; data_in2 = 'hAA;
        @(posedge clk); #1;
        data_in2 = 'hBB;
        @(posedge clk); #1;
        wr_en2 = 1'b0;
        chk("fwft_head_a", data_out2, 'hAA);
        rd_en2 = 1'b1;
        @(posedge clk); #1;
        rd_en2 = 1'b0;
        chk("fwft_head_b", data_out2, 'hBB);
        chk("fwft_count_b", DW'(count2), 1);
        chk("fwft_no_underflow", DW'(underflow2), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
